montgomery_mult: RTL and testbench



---
 rtl/montgomery_mult.sv | 136 +++++++++++++
 tb/tb_montgomery_mult.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/montgomery_mult.sv
// Radix-2 Montgomery modular multiplier: result = A*B*2^(-WIDTH) mod N.
// Each iteration consumes one bit of the latched multiplicand, LSB first.
// A final conditional subtraction brings the accumulator below N.
// An even modulus skips the iterations and reports err with a zero result.
module montgomery_mult #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] modulus,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   // The accumulator stays below 2N, and the sum R + B + N stays below 4N,
   // so two guard bits are enough for the accumulator.
   localparam int RW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [RW-1:0]    r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bad_q, bad_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] res_q, res_d;

   logic [RW-1:0]    t_add, t_red, r_sub;
   logic             last_iter;

   assign last_iter = (cnt_q == CW'(WIDTH - 1));

   // One Montgomery step: add B when a_i is set, then add N when the sum is odd
   // so that the halving is exact. Also form R - N for the final reduction.
   always_comb begin
      t_add = r_q + (a_q[0] ? {2'b00, b_q} : '0);
      t_red = t_add[0] ? (t_add + {2'b00, n_q}) : t_add;
      r_sub = r_q - {2'b00, n_q};
   end

   // Next-state logic. An even modulus goes straight to FINAL.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = modulus[0] ? CALC : FINAL;
         CALC:    if (last_iter) state_d = FINAL;
         FINAL:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output updates for each state. Operands are captured only in
   // IDLE, so port changes during an operation have no effect.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      n_d    = n_q;
      r_d    = r_q;
      cnt_d  = cnt_q;
      bad_d  = bad_q;
      done_d = 1'b0;
      err_d  = err_q;
      res_d  = res_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d   = op_a;
               b_d   = op_b;
               n_d   = modulus;
               r_d   = '0;
               cnt_d = '0;
               bad_d = ~modulus[0];
            end
         end
         CALC: begin
            r_d   = t_red >> 1;
            a_d   = a_q >> 1;
            cnt_d = cnt_q + 1'b1;
         end
         FINAL: begin
            done_d = 1'b1;
            err_d  = bad_q;
            if (bad_q)
               res_d = '0;
            else if (r_q >= {2'b00, n_q})
               res_d = r_sub[WIDTH-1:0];
            else
               res_d = r_q[WIDTH-1:0];
         end
         default: ;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         n_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         bad_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         n_q     <= n_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         bad_q   <= bad_d;
         done_q  <= done_d;
         err_q   <= err_d;
         res_q   <= res_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign err    = err_q;
   assign result = res_q;

endmodule

// File: tb/tb_montgomery_mult.sv
// Directed and randomised checks for montgomery_mult at WIDTH=8.
module tb_montgomery_mult;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] op_a, op_b, modulus;
   logic       busy, done, err;
   logic [7:0] result;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] n;
      logic [7:0] res;
      logic       e;
      int         lat;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   montgomery_mult #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op_a    (op_a),
      .op_b    (op_b),
      .modulus (modulus),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .result  (result)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int inv256(input int n);
      for (int x = 1; x < n; x++)
         if ((256 * x) % n == 1) return x;
      return 0;
   endfunction

   // Start one operation, scramble the ports afterwards, wait (bounded) for done.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                         output int lat, output int bcnt, output int overlap);
      @(negedge clk);
      op_a = a; op_b = b; modulus = n; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op_a = 8'($urandom); op_b = 8'($urandom); modulus = 8'($urandom);
      lat = 0; bcnt = 0; overlap = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      if (busy && done) overlap++;
   endtask

   initial begin
      int lat, bcnt, ov, e, dcnt;
      int n, a, b, exp_r;

      vecs[0] = '{a: 8'd5,   b: 8'd7,   n: 8'd13,  res: 8'd1,   e: 1'b0, lat: 9};
      vecs[1] = '{a: 8'd1,   b: 8'd1,   n: 8'd13,  res: 8'd3,   e: 1'b0, lat: 9};
      vecs[2] = '{a: 8'd0,   b: 8'd12,  n: 8'd13,  res: 8'd0,   e: 1'b0, lat: 9};
      vecs[3] = '{a: 8'd250, b: 8'd250, n: 8'd251, res: 8'd201, e: 1'b0, lat: 9};
      vecs[4] = '{a: 8'd254, b: 8'd1,   n: 8'd255, res: 8'd254, e: 1'b0, lat: 9};
      vecs[5] = '{a: 8'd5,   b: 8'd7,   n: 8'd12,  res: 8'd0,   e: 1'b1, lat: 1};
      vecs[6] = '{a: 8'd5,   b: 8'd7,   n: 8'd13,  res: 8'd1,   e: 1'b0, lat: 9};

      // Reset state
      rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; modulus = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset err", err, 0);
      check("reset result", result, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].n, lat, bcnt, ov);
         check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d result", i), result, vecs[i].res);
         check($sformatf("vec%0d err", i), err, vecs[i].e);
         check($sformatf("vec%0d busy cycles", i), bcnt, vecs[i].lat);
         check($sformatf("vec%0d busy+done overlap", i), ov, 0);
         @(posedge clk); #1;
         check($sformatf("vec%0d done one cycle", i), done, 0);
         if (vecs[i].e) begin
            @(posedge clk); #1;
            check($sformatf("vec%0d err holds", i), err, 1);
            check($sformatf("vec%0d result holds", i), result, 0);
         end
      end

      // Reset mid-CALC: abort with no done afterwards
      @(negedge clk);
      op_a = 8'd5; op_b = 8'd7; modulus = 8'd13; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset result", result, 0);
      check("midreset err", err, 0);
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (done) dcnt++;
      end
      check("midreset no done", dcnt, 0);

      // start held high: back-to-back operations every 10 cycles
      @(negedge clk);
      op_a = 8'd5; op_b = 8'd7; modulus = 8'd13; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         check($sformatf("b2b done k=%0d", k), int'(done), int'((k % 10) == 9));
         if (done) check($sformatf("b2b result k=%0d", k), result, 1);
      end
      @(negedge clk);
      start = 1'b0;
      e = 0;
      while (!done && e < 20) begin
         @(posedge clk); #1;
         e++;
      end
      check("b2b drain done", done, 1);

      // start pulsed during busy is ignored
      @(negedge clk);
      op_a = 8'd1; op_b = 8'd1; modulus = 8'd13; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      op_a = 8'd250; op_b = 8'd250; modulus = 8'd251; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      e = 4;
      check("ignore busy", busy, 1);
      check("ignore result held", result, 1);
      while (!done && e < 40) begin
         @(posedge clk); #1;
         e++;
      end
      check("ignore latency", e, 9);
      check("ignore result", result, 3);
      dcnt = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) dcnt++;
      end
      check("ignore no extra done", dcnt, 0);

      // Randomised sweep against a reference model
      for (int t = 0; t < 20; t++) begin
         n = 2 * $urandom_range(1, 127) + 1;
         a = $urandom_range(0, n - 1);
         b = $urandom_range(0, n - 1);
         exp_r = ((a * b) % n) * inv256(n) % n;
         run_op(8'(a), 8'(b), 8'(n), lat, bcnt, ov);
         check($sformatf("rand N=%0d A=%0d B=%0d result", n, a, b), result, exp_r);
         check($sformatf("rand N=%0d latency", n), lat, 9);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
